// File: rtl/mac_job_sequencer.sv
// Job sequencer for a streaming MAC: sends a bias word, then joined weight/activation
// pairs, then collects the MAC result. Define MAC_SEQ_STATS_EN to add the JOB_CYCLES output.
module mac_job_sequencer (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CMD_TVALID,
  output logic        CMD_TREADY,
  input  logic [15:0] CMD_BIAS,
  input  logic [7:0]  CMD_LEN,
  input  logic        SA_AXIS_TVALID,
  output logic        SA_AXIS_TREADY,
  input  logic [7:0]  SA_AXIS_TDATA,
  input  logic        SW_AXIS_TVALID,
  output logic        SW_AXIS_TREADY,
  input  logic [7:0]  SW_AXIS_TDATA,
  output logic        MO_AXIS_TVALID,
  input  logic        MO_AXIS_TREADY,
  output logic [15:0] MO_AXIS_TDATA,
  output logic        MO_AXIS_TLAST,
  input  logic        SR_AXIS_TVALID,
  output logic        SR_AXIS_TREADY,
  input  logic [31:0] SR_AXIS_TDATA,
  output logic        RES_TVALID,
  input  logic        RES_TREADY,
  output logic [31:0] RES_TDATA,
  output logic        BUSY
`ifdef MAC_SEQ_STATS_EN
  ,
  output logic [31:0] JOB_CYCLES
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_PAIRS,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] bias_reg;
  logic [7:0]  len_reg;
  logic [7:0]  cnt_reg;
  logic        cmd_ready_reg;
  logic        sr_ready_reg;
  logic        res_valid_reg;
  logic [31:0] res_data_reg;

  logic in_pairs;
  logic pair_valid;
  logic pair_last;
  logic cmd_hs;
  logic mo_hs;
  logic sr_hs;
  logic res_hs;

  // Pairs pass straight through: the MAC port is valid only when both streams are.
  assign in_pairs       = (state_reg == S_PAIRS);
  assign pair_valid     = SA_AXIS_TVALID & SW_AXIS_TVALID;
  assign pair_last      = (cnt_reg == len_reg - 8'd1);

  assign MO_AXIS_TVALID = in_pairs ? pair_valid : (state_reg == S_BIAS);
  assign MO_AXIS_TDATA  = in_pairs ? {SW_AXIS_TDATA, SA_AXIS_TDATA} : bias_reg;
  assign MO_AXIS_TLAST  = in_pairs ? pair_last : ((state_reg == S_BIAS) && (len_reg == 8'd0));
  assign SA_AXIS_TREADY = in_pairs & pair_valid & MO_AXIS_TREADY;
  assign SW_AXIS_TREADY = in_pairs & pair_valid & MO_AXIS_TREADY;

  assign CMD_TREADY     = cmd_ready_reg;
  assign SR_AXIS_TREADY = sr_ready_reg;
  assign RES_TVALID     = res_valid_reg;
  assign RES_TDATA      = res_data_reg;
  assign BUSY           = (state_reg != S_IDLE);

  assign cmd_hs = CMD_TVALID & cmd_ready_reg;
  assign mo_hs  = MO_AXIS_TVALID & MO_AXIS_TREADY;
  assign sr_hs  = SR_AXIS_TVALID & sr_ready_reg;
  assign res_hs = res_valid_reg & RES_TREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= S_IDLE;
      bias_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      sr_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_hs) begin
            bias_reg      <= CMD_BIAS;
            len_reg       <= CMD_LEN;
            cnt_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            state_reg     <= S_BIAS;
          end
        end
        S_BIAS: begin
          if (mo_hs) begin
            if (len_reg == 8'd0) begin
              sr_ready_reg <= 1'b1;
              state_reg    <= S_WAIT_RES;
            end else begin
              state_reg    <= S_PAIRS;
            end
          end
        end
        S_PAIRS: begin
          // Counter tops out at LEN (max 255), so it cannot wrap.
          if (mo_hs) begin
            cnt_reg <= cnt_reg + 8'd1;
            if (pair_last) begin
              sr_ready_reg <= 1'b1;
              state_reg    <= S_WAIT_RES;
            end
          end
        end
        S_WAIT_RES: begin
          if (sr_hs) begin
            res_data_reg  <= SR_AXIS_TDATA;
            sr_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_hs) begin
            res_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_reg <= 1'b0;
          sr_ready_reg  <= 1'b0;
          res_valid_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_STATS_EN
  logic [31:0] run_cnt_reg;
  logic [31:0] job_cycles_reg;

  // run_cnt_reg holds the cycles elapsed before the current one; +1 includes the RES cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run_cnt_reg    <= '0;
      job_cycles_reg <= '0;
    end else begin
      if (cmd_hs) begin
        run_cnt_reg <= 32'd1;
      end else if (BUSY) begin
        run_cnt_reg <= run_cnt_reg + 32'd1;
      end
      if (res_hs) begin
        job_cycles_reg <= run_cnt_reg + 32'd1;
      end
    end
  end

  assign JOB_CYCLES = job_cycles_reg;
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural MAC and two byte-stream sources.
`timescale 1ns/1ps
module tb_mac_job_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        CMD_TVALID;
  logic        CMD_TREADY;
  logic [15:0] CMD_BIAS;
  logic [7:0]  CMD_LEN;
  logic        SA_AXIS_TVALID;
  logic        SA_AXIS_TREADY;
  logic [7:0]  SA_AXIS_TDATA;
  logic        SW_AXIS_TVALID;
  logic        SW_AXIS_TREADY;
  logic [7:0]  SW_AXIS_TDATA;
  logic        MO_AXIS_TVALID;
  logic        MO_AXIS_TREADY;
  logic [15:0] MO_AXIS_TDATA;
  logic        MO_AXIS_TLAST;
  logic        SR_AXIS_TVALID;
  logic        SR_AXIS_TREADY;
  logic [31:0] SR_AXIS_TDATA;
  logic        RES_TVALID;
  logic        RES_TREADY;
  logic [31:0] RES_TDATA;
  logic        BUSY;
`ifdef MAC_SEQ_STATS_EN
  logic [31:0] JOB_CYCLES;
`endif

  int errors = 0;
  int checks = 0;

  mac_job_sequencer dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .CMD_TVALID     (CMD_TVALID),
    .CMD_TREADY     (CMD_TREADY),
    .CMD_BIAS       (CMD_BIAS),
    .CMD_LEN        (CMD_LEN),
    .SA_AXIS_TVALID (SA_AXIS_TVALID),
    .SA_AXIS_TREADY (SA_AXIS_TREADY),
    .SA_AXIS_TDATA  (SA_AXIS_TDATA),
    .SW_AXIS_TVALID (SW_AXIS_TVALID),
    .SW_AXIS_TREADY (SW_AXIS_TREADY),
    .SW_AXIS_TDATA  (SW_AXIS_TDATA),
    .MO_AXIS_TVALID (MO_AXIS_TVALID),
    .MO_AXIS_TREADY (MO_AXIS_TREADY),
    .MO_AXIS_TDATA  (MO_AXIS_TDATA),
    .MO_AXIS_TLAST  (MO_AXIS_TLAST),
    .SR_AXIS_TVALID (SR_AXIS_TVALID),
    .SR_AXIS_TREADY (SR_AXIS_TREADY),
    .SR_AXIS_TDATA  (SR_AXIS_TDATA),
    .RES_TVALID     (RES_TVALID),
    .RES_TREADY     (RES_TREADY),
    .RES_TDATA      (RES_TDATA),
    .BUSY           (BUSY)
`ifdef MAC_SEQ_STATS_EN
    ,
    .JOB_CYCLES     (JOB_CYCLES)
`endif
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Shared state: each variable has exactly one writing process.
  bit         flush = 1'b0;
  bit         stall_en = 1'b0;
  int         sa_gate = 0, sw_gate = 0;
  logic [7:0] sa_mem [0:1023];
  logic [7:0] sw_mem [0:1023];
  int         sa_wr = 0, sw_wr = 0;
  int         sa_rd, sw_rd, sa_cnt, sw_cnt;
  bit         sa_hs, sw_hs;
  logic [16:0] mac_log [0:1023];
  int          mac_log_n = 0;

  // Activation source: everything drives on the falling edge, handshakes judged 1 ns later.
  initial begin
    SA_AXIS_TVALID = 1'b0; SA_AXIS_TDATA = '0; sa_rd = 0; sa_cnt = 0; sa_hs = 1'b0;
    forever begin
      @(negedge ACLK);
      if (flush) begin
        sa_rd = 0; sa_hs = 1'b0; SA_AXIS_TVALID = 1'b0;
      end else begin
        if (sa_hs) begin sa_rd++; sa_cnt++; end
        SA_AXIS_TVALID = (sa_rd < sa_wr) && (cyc >= sa_gate);
        SA_AXIS_TDATA  = (sa_rd < sa_wr) ? sa_mem[sa_rd] : 8'h00;
        #1;
        sa_hs = SA_AXIS_TVALID & SA_AXIS_TREADY;
      end
    end
  end

  initial begin
    SW_AXIS_TVALID = 1'b0; SW_AXIS_TDATA = '0; sw_rd = 0; sw_cnt = 0; sw_hs = 1'b0;
    forever begin
      @(negedge ACLK);
      if (flush) begin
        sw_rd = 0; sw_hs = 1'b0; SW_AXIS_TVALID = 1'b0;
      end else begin
        if (sw_hs) begin sw_rd++; sw_cnt++; end
        SW_AXIS_TVALID = (sw_rd < sw_wr) && (cyc >= sw_gate);
        SW_AXIS_TDATA  = (sw_rd < sw_wr) ? sw_mem[sw_rd] : 8'h00;
        #1;
        sw_hs = SW_AXIS_TVALID & SW_AXIS_TREADY;
      end
    end
  end

  // Behavioural MAC: first word of a job is the bias, the rest are {w,a} products.
  initial begin
    logic signed [31:0] acc;
    logic signed [7:0]  wv, av;
    bit first, res_pend, sr_hs;
    acc = 0; first = 1'b1; res_pend = 1'b0; sr_hs = 1'b0;
    MO_AXIS_TREADY = 1'b0; SR_AXIS_TVALID = 1'b0; SR_AXIS_TDATA = '0;
    forever begin
      @(negedge ACLK);
      if (flush) begin
        acc = 0; first = 1'b1; res_pend = 1'b0; sr_hs = 1'b0;
        SR_AXIS_TVALID = 1'b0; MO_AXIS_TREADY = 1'b0;
      end else begin
        if (sr_hs) begin SR_AXIS_TVALID = 1'b0; acc = 0; first = 1'b1; end
        if (res_pend) begin SR_AXIS_TVALID = 1'b1; SR_AXIS_TDATA = acc; res_pend = 1'b0; end
        MO_AXIS_TREADY = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        sr_hs = SR_AXIS_TVALID & SR_AXIS_TREADY;
        if (MO_AXIS_TVALID && MO_AXIS_TREADY) begin
          mac_log[mac_log_n] = {MO_AXIS_TLAST, MO_AXIS_TDATA};
          mac_log_n++;
          if (first) begin
            acc = {{16{MO_AXIS_TDATA[15]}}, MO_AXIS_TDATA};
            first = 1'b0;
          end else begin
            wv = MO_AXIS_TDATA[15:8];
            av = MO_AXIS_TDATA[7:0];
            acc = acc + wv * av;
          end
          if (MO_AXIS_TLAST) res_pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge ACLK);
    #2;
  endtask

  task automatic push_pair(input logic signed [7:0] w, input logic signed [7:0] a);
    sa_mem[sa_wr] = a; sa_wr++;
    sw_mem[sw_wr] = w; sw_wr++;
  endtask

  task automatic issue_cmd(input logic [15:0] bias, input logic [7:0] len, output bit to);
    int n;
    n = 0; to = 1'b0;
    CMD_BIAS = bias; CMD_LEN = len; CMD_TVALID = 1'b1;
    while (CMD_TREADY !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) to = 1'b1;
    tick();
    CMD_TVALID = 1'b0;
  endtask

  task automatic wait_res(output bit to);
    int n;
    n = 0;
    while (RES_TVALID !== 1'b1 && n < 2000) begin tick(); n++; end
    to = (n >= 2000);
  endtask

  // Runs one job with RES_TREADY high; cycles counts CMD-handshake cycle to RES-handshake cycle.
  task automatic run_job(input logic [15:0] bias, input logic [7:0] len,
                         output logic [31:0] res, output int cycles, output bit to);
    int n;
    bit to_cmd;
    issue_cmd(bias, len, to_cmd);
    cycles = 2; n = 0;
    while (!(RES_TVALID === 1'b1 && RES_TREADY === 1'b1) && n < 2000) begin
      tick(); cycles++; n++;
    end
    to = to_cmd || (n >= 2000);
    res = RES_TDATA;
    tick();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; CMD_TVALID = 1'b0; CMD_BIAS = '0; CMD_LEN = '0; RES_TREADY = 1'b1;
    tick(); tick();
    checks++;
    if ({CMD_TREADY, SA_AXIS_TREADY, SW_AXIS_TREADY, MO_AXIS_TVALID, SR_AXIS_TREADY, RES_TVALID, BUSY} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {CMD_TREADY, SA_AXIS_TREADY, SW_AXIS_TREADY, MO_AXIS_TVALID, SR_AXIS_TREADY, RES_TVALID, BUSY});
    end
    checks++;
    if (RES_TDATA !== 32'd0) begin errors++; $display("FAIL reset_res: got %h expected 0", RES_TDATA); end
    ARESETN = 1'b1;
    tick();
    checks++;
    if (CMD_TREADY !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", CMD_TREADY); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] res; int cyc_n; bit to; int base;
    logic [16:0] exp_w [0:2];
    exp_w = '{17'h0_0005, 17'h0_F605, 17'h1_1964};
    base = mac_log_n;
    push_pair(-8'sd10, 8'sd5);
    push_pair(8'sd25, 8'sd100);
    run_job(16'd5, 8'd2, res, cyc_n, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got timeout expected result"); end
    checks++;
    if (res !== 32'd2455) begin errors++; $display("FAIL basic_res: got %0d expected 2455", $signed(res)); end
    checks++;
    if (mac_log_n - base !== 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", mac_log_n - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mac_log[base+i] !== exp_w[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h expected %h", i, mac_log[base+i], exp_w[i]);
      end
    end
`ifdef MAC_SEQ_STATS_EN
    checks++;
    if (JOB_CYCLES !== 32'(cyc_n)) begin errors++; $display("FAIL basic_cycles: got %0d expected %0d", JOB_CYCLES, cyc_n); end
`endif
    $display("test_basic: res=%0d words=%0d", $signed(res), mac_log_n - base);
  endtask

  task automatic test_three_pairs();
    logic [31:0] res; int cyc_n; bit to; int base;
    logic [16:0] exp_w [0:3];
    exp_w = '{17'h0_FBFC, 17'h0_86F1, 17'h0_77FD, 17'h1_950D};
    base = mac_log_n;
    push_pair(-8'sd122, -8'sd15);
    push_pair(8'sd119, -8'sd3);
    push_pair(-8'sd107, 8'sd13);
    run_job(16'hFBFC, 8'd3, res, cyc_n, to);
    checks++;
    if (to) begin errors++; $display("FAIL three_timeout: got timeout expected result"); end
    checks++;
    if (res !== 32'hFFFF_FC4E) begin errors++; $display("FAIL three_res: got %0d expected -946", $signed(res)); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mac_log[base+i] !== exp_w[i]) begin
        errors++; $display("FAIL three_word%0d: got %h expected %h", i, mac_log[base+i], exp_w[i]);
      end
    end
    $display("test_three_pairs: res=%0d", $signed(res));
  endtask

  // A pair is left waiting in the streams; a bias-only job must not touch it.
  task automatic test_len_zero();
    logic [31:0] res; int cyc_n; bit to; int base, sa0, sw0;
    base = mac_log_n; sa0 = sa_cnt; sw0 = sw_cnt;
    push_pair(8'sd2, 8'sd3);
    run_job(16'd300, 8'd0, res, cyc_n, to);
    checks++;
    if (to) begin errors++; $display("FAIL len0_timeout: got timeout expected result"); end
    checks++;
    if (res !== 32'd300) begin errors++; $display("FAIL len0_res: got %0d expected 300", $signed(res)); end
    checks++;
    if (mac_log_n - base !== 1 || mac_log[base] !== 17'h1_012C) begin
      errors++; $display("FAIL len0_word: got %h (n=%0d) expected 1012c (n=1)", mac_log[base], mac_log_n - base);
    end
    checks++;
    if (sa_cnt !== sa0 || sw_cnt !== sw0) begin
      errors++; $display("FAIL len0_streams: got sa=%0d sw=%0d handshakes expected 0", sa_cnt - sa0, sw_cnt - sw0);
    end
    $display("test_len_zero: res=%0d", $signed(res));
  endtask

  // Uses the pair (2,3) left over from the bias-only job.
  task automatic test_res_backpressure();
    bit to;
    RES_TREADY = 1'b0;
    issue_cmd(16'd10, 8'd1, to);
    wait_res(to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout: got timeout expected RES_TVALID"); end
    CMD_BIAS = 16'd7; CMD_LEN = 8'd0; CMD_TVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (CMD_TREADY !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready c%0d: got %b expected 0", i, CMD_TREADY); end
      checks++;
      if (RES_TVALID !== 1'b1 || RES_TDATA !== 32'd16) begin
        errors++; $display("FAIL bp_res_hold c%0d: got v=%b d=%0d expected v=1 d=16", i, RES_TVALID, RES_TDATA);
      end
      tick();
    end
    RES_TREADY = 1'b1;
    tick();
    checks++;
    if (RES_TVALID !== 1'b0 || CMD_TREADY !== 1'b1) begin
      errors++; $display("FAIL bp_release: got res_v=%b cmd_rdy=%b expected 0 1", RES_TVALID, CMD_TREADY);
    end
    tick();
    CMD_TVALID = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL bp_next_start: got busy=%b expected 1", BUSY); end
    wait_res(to);
    checks++;
    if (to || RES_TDATA !== 32'd7) begin errors++; $display("FAIL bp_next_res: got %0d expected 7", RES_TDATA); end
    tick();
    $display("test_res_backpressure done");
  endtask

  task automatic test_skew_stall();
    bit to, prev_stall;
    logic [15:0] prev_data;
    int base, n, skew_seen;
    logic [16:0] exp_w [0:2];
    exp_w = '{17'h0_0064, 17'h0_0304, 17'h1_FB06};
    base = mac_log_n; n = 0; skew_seen = 0; prev_stall = 1'b0; prev_data = '0;
    stall_en = 1'b1;
    sa_gate = cyc + 2;
    sw_gate = cyc + 5;
    push_pair(8'sd3, 8'sd4);
    push_pair(-8'sd5, 8'sd6);
    issue_cmd(16'd100, 8'd2, to);
    while (RES_TVALID !== 1'b1 && n < 300) begin
      if (SA_AXIS_TVALID === 1'b1 && SW_AXIS_TVALID !== 1'b1) begin
        skew_seen++;
        checks++;
        if (SA_AXIS_TREADY !== 1'b0 || MO_AXIS_TVALID === 1'b1 && MO_AXIS_TDATA[7:0] === 8'h04) begin
          errors++; $display("FAIL skew_early: got sa_rdy=%b mo=%h expected no pair", SA_AXIS_TREADY, MO_AXIS_TDATA);
        end
      end
      if (prev_stall) begin
        checks++;
        if (MO_AXIS_TVALID !== 1'b1 || MO_AXIS_TDATA !== prev_data) begin
          errors++; $display("FAIL skew_hold: got v=%b d=%h expected v=1 d=%h", MO_AXIS_TVALID, MO_AXIS_TDATA, prev_data);
        end
      end
      prev_stall = (MO_AXIS_TVALID === 1'b1) && (MO_AXIS_TREADY === 1'b0);
      prev_data  = MO_AXIS_TDATA;
      tick(); n++;
    end
    checks++;
    if (to || n >= 300) begin errors++; $display("FAIL skew_timeout: got timeout expected result"); end
    checks++;
    if (skew_seen !== 3) begin errors++; $display("FAIL skew_window: got %0d cycles expected 3", skew_seen); end
    checks++;
    if (RES_TDATA !== 32'd82) begin errors++; $display("FAIL skew_res: got %0d expected 82", $signed(RES_TDATA)); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mac_log[base+i] !== exp_w[i]) begin
        errors++; $display("FAIL skew_word%0d: got %h expected %h", i, mac_log[base+i], exp_w[i]);
      end
    end
    tick();
    stall_en = 1'b0; sa_gate = 0; sw_gate = 0;
    $display("test_skew_stall: res=%0d", $signed(RES_TDATA));
  endtask

  task automatic test_len_max();
    logic [31:0] res; int cyc_n; bit to; int base, nlast, nbad;
    base = mac_log_n; nlast = 0; nbad = 0;
    for (int i = 0; i < 255; i++) push_pair(8'sd1, 8'sd1);
    run_job(16'd0, 8'd255, res, cyc_n, to);
    checks++;
    if (to || res !== 32'd255) begin errors++; $display("FAIL max_res: got %0d expected 255", $signed(res)); end
    checks++;
    if (mac_log_n - base !== 256) begin errors++; $display("FAIL max_count: got %0d expected 256", mac_log_n - base); end
    for (int i = 1; i < 256; i++) begin
      if (mac_log[base+i][16]) nlast++;
      if (mac_log[base+i][15:0] !== 16'h0101) nbad++;
    end
    checks++;
    if (nlast !== 1 || mac_log[base+255][16] !== 1'b1 || nbad !== 0) begin
      errors++; $display("FAIL max_words: got last=%0d bad=%0d expected last=1 bad=0", nlast, nbad);
    end
    $display("test_len_max: res=%0d", $signed(res));
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] res; int cyc_n; bit to; int base, c0, n;
    c0 = sa_cnt; n = 0;
    for (int i = 0; i < 4; i++) push_pair(8'sd1, 8'sd2);
    issue_cmd(16'd1234, 8'd4, to);
    while (sa_cnt - c0 < 2 && n < 200) begin tick(); n++; end
    checks++;
    if (to || n >= 200) begin errors++; $display("FAIL rstmid_reach: got timeout expected PAIRS"); end
    ARESETN = 1'b0; flush = 1'b1; sa_wr = 0; sw_wr = 0;
    #1;
    checks++;
    if ({CMD_TREADY, SA_AXIS_TREADY, SW_AXIS_TREADY, MO_AXIS_TVALID, SR_AXIS_TREADY, RES_TVALID, BUSY} !== 7'b0 || RES_TDATA !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b res=%h expected 0000000 res=0", {CMD_TREADY, SA_AXIS_TREADY, SW_AXIS_TREADY, MO_AXIS_TVALID, SR_AXIS_TREADY, RES_TVALID, BUSY}, RES_TDATA);
    end
    tick();
    ARESETN = 1'b1; flush = 1'b0;
    tick();
    checks++;
    if (CMD_TREADY !== 1'b1 || RES_TVALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: got rdy=%b res_v=%b busy=%b expected 1 0 0", CMD_TREADY, RES_TVALID, BUSY);
    end
    base = mac_log_n;
    push_pair(8'h80, 8'h80);
    run_job(16'd5000, 8'd1, res, cyc_n, to);
    checks++;
    if (to || res !== 32'd21384) begin errors++; $display("FAIL rstmid_res: got %0d expected 21384", $signed(res)); end
    checks++;
    if (mac_log[base] !== 17'h0_1388 || mac_log[base+1] !== 17'h1_8080) begin
      errors++; $display("FAIL rstmid_words: got %h %h expected 01388 18080", mac_log[base], mac_log[base+1]);
    end
`ifdef MAC_SEQ_STATS_EN
    checks++;
    if (JOB_CYCLES !== 32'(cyc_n)) begin errors++; $display("FAIL rstmid_cycles: got %0d expected %0d", JOB_CYCLES, cyc_n); end
`endif
    $display("test_reset_mid_job: res=%0d cycles=%0d", $signed(res), cyc_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_three_pairs();
    test_len_zero();
    test_res_backpressure();
    test_skew_stall();
    test_len_max();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
